// File: rtl/config_shift_loader.sv
// Head-of-chain configuration loader: serialises valid/ready config words LSB-first into the tile shift chain.
// Optional readback collector of the chain tail enabled by defining CONFIG_READBACK_EN.
module config_shift_loader #(
  parameter int unsigned CHAIN_LEN = 256,
  parameter int unsigned WORD_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              cen,
  output logic              shift_in,
  output logic              set_in,
  input  logic              shift_out,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int unsigned NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int unsigned LAST_BITS = ((CHAIN_LEN % WORD_W) == 0) ? WORD_W : (CHAIN_LEN % WORD_W);
  localparam int unsigned BC_W      = $clog2(CHAIN_LEN + 1);
  localparam int unsigned AC_W      = $clog2(WORD_W + 1);
  localparam int unsigned WA_W      = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, SET, DONE} state_t;

  state_t            state;
  logic [BC_W-1:0]   bit_cnt;
  logic [WA_W-1:0]   words_acc;
  logic [WORD_W-1:0] act;
  logic [AC_W-1:0]   act_cnt;
  logic [WORD_W-1:0] skid;
  logic [AC_W-1:0]   skid_len;
  logic              skid_full;
  logic              accept;
  logic [AC_W-1:0]   acc_len;

  assign cfg_ready = !skid_full && (state == IDLE || state == SHIFT) && (words_acc < WA_W'(NWORDS));
  assign accept    = cfg_valid && cfg_ready;
  // Only the low LAST_BITS of the final word are ever presented to the chain.
  assign acc_len   = (words_acc == WA_W'(NWORDS - 1)) ? AC_W'(LAST_BITS) : AC_W'(WORD_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cen       <= 1'b0;
      shift_in  <= 1'b0;
      set_in    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_cnt   <= '0;
      words_acc <= '0;
      act       <= '0;
      act_cnt   <= '0;
      skid      <= '0;
      skid_len  <= '0;
      skid_full <= 1'b0;
    end else begin
      case (state)
        IDLE, SHIFT: begin
          if (accept) words_acc <= words_acc + WA_W'(1);
          if (state == SHIFT && bit_cnt == BC_W'(CHAIN_LEN)) begin
            state    <= SET;
            cen      <= 1'b1;
            shift_in <= 1'b0;
            set_in   <= 1'b1;
          end else if (act_cnt != '0) begin
            cen      <= 1'b1;
            shift_in <= act[0];
            act      <= act >> 1;
            act_cnt  <= act_cnt - AC_W'(1);
            bit_cnt  <= bit_cnt + BC_W'(1);
            if (accept) begin
              skid      <= cfg_data;
              skid_len  <= acc_len;
              skid_full <= 1'b1;
            end
          end else if (skid_full) begin
            cen       <= 1'b1;
            shift_in  <= skid[0];
            act       <= skid >> 1;
            act_cnt   <= skid_len - AC_W'(1);
            bit_cnt   <= bit_cnt + BC_W'(1);
            skid_full <= 1'b0;
          end else if (accept) begin
            // Active register and skid both empty: the new word bypasses the skid.
            cen      <= 1'b1;
            shift_in <= cfg_data[0];
            act      <= cfg_data >> 1;
            act_cnt  <= acc_len - AC_W'(1);
            bit_cnt  <= bit_cnt + BC_W'(1);
            state    <= SHIFT;
            busy     <= 1'b1;
          end else begin
            cen <= 1'b0;
          end
        end
        SET: begin
          state  <= DONE;
          cen    <= 1'b0;
          set_in <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          bit_cnt   <= '0;
          words_acc <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONFIG_READBACK_EN
  localparam int unsigned RC_W = $clog2(WORD_W);

  logic [WORD_W-1:0] rb_col;
  logic [WORD_W-1:0] rb_next;
  logic [RC_W-1:0]   rb_cnt;

  always_comb begin
    rb_next         = rb_col;
    rb_next[rb_cnt] = shift_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rb_col   <= '0;
      rb_cnt   <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (state == SHIFT && cen) begin
        // A partial final word leaves its high bits zero because the collector restarts cleared.
        if (rb_cnt == RC_W'(WORD_W - 1) || bit_cnt == BC_W'(CHAIN_LEN)) begin
          rb_data  <= rb_next;
          rb_valid <= 1'b1;
          rb_col   <= '0;
          rb_cnt   <= '0;
        end else begin
          rb_col <= rb_next;
          rb_cnt <= rb_cnt + RC_W'(1);
        end
      end
    end
  end
`else
  logic unused_shift_out;

  assign unused_shift_out = shift_out;
  assign rb_data          = '0;
  assign rb_valid         = 1'b0;
`endif

endmodule

// File: tb/tb_config_shift_loader.sv
// Directed bench for config_shift_loader: a 40-bit/16-bit chain instance and a 32-bit/32-bit instance.
module tb_config_shift_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, cfg_valid_a, cfg_ready_a, cen_a, shift_in_a, set_in_a, shift_out_a;
  logic        busy_a, done_a, rb_valid_a;
  logic [15:0] cfg_data_a, rb_data_a;

  logic        rst_b, cfg_valid_b, cfg_ready_b, cen_b, shift_in_b, set_in_b, shift_out_b;
  logic        busy_b, done_b, rb_valid_b;
  logic [31:0] cfg_data_b, rb_data_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] rb_q[$];
  logic [39:0] chain;
  logic        preload;

  config_shift_loader #(.CHAIN_LEN(40), .WORD_W(16)) dut_a (
    .clk(clk), .rst(rst_a), .cfg_data(cfg_data_a), .cfg_valid(cfg_valid_a), .cfg_ready(cfg_ready_a),
    .cen(cen_a), .shift_in(shift_in_a), .set_in(set_in_a), .shift_out(shift_out_a),
    .busy(busy_a), .done(done_a), .rb_data(rb_data_a), .rb_valid(rb_valid_a)
  );

  config_shift_loader #(.CHAIN_LEN(32), .WORD_W(32)) dut_b (
    .clk(clk), .rst(rst_b), .cfg_data(cfg_data_b), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
    .cen(cen_b), .shift_in(shift_in_b), .set_in(set_in_b), .shift_out(shift_out_b),
    .busy(busy_b), .done(done_b), .rb_data(rb_data_b), .rb_valid(rb_valid_b)
  );

  // Chain model for instance A: head at shift_in, tail at shift_out.
  always @(posedge clk) begin
    if (preload) chain <= 40'h12_3456_789A;
    else if (cen_a && !set_in_a) chain <= {shift_in_a, chain[39:1]};
  end
  assign shift_out_a = chain[0];
  assign shift_out_b = 1'b0;

  always @(negedge clk) if (rb_valid_a) rb_q.push_back(rb_data_a);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_rst();
    rst_a = 1'b1;
    rst_b = 1'b1;
    cfg_valid_a = 1'b0;
    cfg_valid_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
  endtask

  // Drives the three-word load on instance A; cycle numbers are relative to the first accepted word.
  task automatic load_a(input int gap, input int exp_set, input int exp_stall, input bit hold4, input int rst_at);
    logic [15:0] w [3];
    logic [39:0] bits;
    int c0 = -1, nacc = 0, nshift = 0, nstall = 0, set_cyc = -1, done_cyc = -1, gapc = 0, rdy_hi = 0;
    w[0] = 16'hA5C3;
    w[1] = 16'h0FF0;
    w[2] = 16'hAB5A;
    bits = {w[2][7:0], w[1], w[0]};
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (c0 >= 0) begin
        if (cen_a && !set_in_a) begin
          if (nshift < 40) check("shift_bit", shift_in_a, bits[nshift]);
          nshift++;
          if (nshift == 1) check("busy_shift", busy_a, 1'b1);
        end else if (!set_in_a && !done_a && set_cyc < 0) begin
          nstall++;
          check("stall_hold", shift_in_a, bits[nshift-1]);
        end
        if (set_in_a && set_cyc < 0) begin
          set_cyc = t - c0;
          check("set_outputs", {cen_a, shift_in_a, busy_a}, 3'b101);
        end
        if (done_a) begin
          done_cyc = t - c0;
          check("done_outputs", {cen_a, busy_a, set_in_a}, 3'b000);
        end
        if (nacc == 3 && done_cyc < 0 && cfg_ready_a) rdy_hi++;
      end
      if (rst_at >= 0 && nshift == rst_at) begin
        rst_a = 1'b1;
        cfg_valid_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;
        check("midload_reset", {cfg_ready_a, cen_a, shift_in_a, set_in_a, busy_a, done_a, rb_valid_a}, 7'b1000000);
        check("midload_rb_data", rb_data_a, 16'h0);
        return;
      end
      if (done_cyc >= 0 && !hold4) break;
      if (nacc < 3) begin
        if (nacc == 1 && gapc < gap) begin
          cfg_valid_a = 1'b0;
          gapc++;
        end else begin
          cfg_valid_a = 1'b1;
          cfg_data_a  = w[nacc];
        end
      end else if (hold4) begin
        cfg_valid_a = 1'b1;
        cfg_data_a  = 16'h1235;
      end else begin
        cfg_valid_a = 1'b0;
      end
      if (cfg_valid_a && cfg_ready_a) begin
        if (nacc == 3) begin
          check("w4_accept_cycle", t - c0, exp_set + 2);
          @(negedge clk);
          cfg_valid_a = 1'b0;
          check("w4_first_bit", {cen_a, shift_in_a, busy_a}, 3'b111);
          break;
        end
        if (nacc == 0) c0 = t;
        nacc++;
      end
    end
    cfg_valid_a = 1'b0;
    check("n_shift", nshift, 40);
    check("n_stall", nstall, exp_stall);
    check("set_cycle", set_cyc, exp_set);
    check("done_cycle", done_cyc, exp_set + 1);
    check("ready_low_when_full", rdy_hi, 0);
  endtask

  task automatic load_b();
    logic [31:0] word;
    int nb = 0, setb = -1, doneb = -1, rdyb = 0;
    word = 32'hDEADBEEF;
    @(negedge clk);
    cfg_valid_b = 1'b1;
    cfg_data_b  = word;
    check("b_ready_idle", cfg_ready_b, 1'b1);
    for (int t = 1; t < 80; t++) begin
      @(negedge clk);
      cfg_valid_b = 1'b0;
      if (cen_b && !set_in_b) begin
        if (nb < 32) check("b_shift_bit", shift_in_b, word[nb]);
        nb++;
      end
      if (set_in_b && setb < 0) setb = t;
      if (done_b) begin
        doneb = t;
        break;
      end
      if (cfg_ready_b) rdyb++;
    end
    check("b_n_shift", nb, 32);
    check("b_set_cycle", setb, 33);
    check("b_done_cycle", doneb, 34);
    check("b_ready_low", rdyb, 0);
    @(negedge clk);
    check("b_ready_after_done", cfg_ready_b, 1'b1);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    preload = 1'b1;
    cfg_valid_a = 1'b0;
    cfg_valid_b = 1'b0;
    cfg_data_a = '0;
    cfg_data_b = '0;
    repeat (3) @(negedge clk);
    check("a_reset", {cfg_ready_a, cen_a, shift_in_a, set_in_a, busy_a, done_a, rb_valid_a}, 7'b1000000);
    check("a_reset_rb_data", rb_data_a, 16'h0);
    check("b_reset", {cfg_ready_b, cen_b, shift_in_b, set_in_b, busy_b, done_b, rb_valid_b}, 7'b1000000);
    rst_a = 1'b0;
    rst_b = 1'b0;
    preload = 1'b0;
    rb_q.delete();

    load_a(0, 41, 0, 1'b0, -1);
`ifdef CONFIG_READBACK_EN
    check("rb_count", rb_q.size(), 3);
    if (rb_q.size() == 3) begin
      check("rb_word0", rb_q[0], 16'h789A);
      check("rb_word1", rb_q[1], 16'h3456);
      check("rb_word2", rb_q[2], 16'h0012);
    end
`endif
    load_a(20, 46, 5, 1'b0, -1);
    load_a(0, 41, 0, 1'b1, -1);
    pulse_rst();
    load_a(0, 41, 0, 1'b0, 20);
    load_a(0, 41, 0, 1'b0, -1);
    load_b();
`ifndef CONFIG_READBACK_EN
    check("rb_silent", rb_q.size(), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
